pipe_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage vector pipeline (Fetch/Decode/Execute/Memory/WriteBack pipe registers).

---
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage vector pipeline. It drives the per-stage load enables and
// bubble flushes, and it handles load-use stalls, taken branches, vector memory waits and halt/restart.
module pipe_hazard_ctrl #(
  parameter int AW           = 4,
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] RA1D,
  input  logic [AW-1:0] RA2D,
  input  logic [AW-1:0] WA3E,
  input  logic          RegWriteE,
  input  logic          MemtoRegE,
  input  logic          PCSrcE,
  input  logic          MemAccessM,
  input  logic          HaltD,
  input  logic          mem_ack,
  output logic          cargar_f,
  output logic          cargar_d,
  output logic          cargar_e,
  output logic          cargar_m,
  output logic          cargar_w,
  output logic          flush_d,
  output logic          flush_e,
  output logic          mem_req,
  output logic          halted,
  output logic          mem_err,
  output logic [CW-1:0] stall_count
);

  localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MEM_TIMEOUT);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_MEM_WAIT,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [DW-1:0] drain_cnt;
  logic          ret_drain;
  logic          load_use;
  logic          stall_inc;

  assign load_use = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));

  // The entry cycle of a memory access freezes every stage, because the access must wait for mem_ack.
  always_comb begin
    cargar_f  = 1'b0;
    cargar_d  = 1'b0;
    cargar_e  = 1'b0;
    cargar_m  = 1'b0;
    cargar_w  = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    stall_inc = 1'b0;
    case (state)
      S_RUN: begin
        if (MemAccessM) begin
          stall_inc = 1'b1;
        end else if (PCSrcE) begin
          {cargar_f, cargar_d, cargar_e, cargar_m, cargar_w} = 5'b11111;
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          {cargar_e, cargar_m, cargar_w} = 3'b111;
          flush_e   = 1'b1;
          stall_inc = 1'b1;
        end else if (HaltD) begin
          {cargar_d, cargar_e, cargar_m, cargar_w} = 4'b1111;
          flush_d = 1'b1;
        end else begin
          {cargar_f, cargar_d, cargar_e, cargar_m, cargar_w} = 5'b11111;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack) begin
          {cargar_f, cargar_d, cargar_e, cargar_m, cargar_w} = 5'b11111;
        end else begin
          stall_inc = 1'b1;
        end
      end
      S_DRAIN: begin
        if (MemAccessM) begin
          stall_inc = 1'b1;
        end else begin
          {cargar_d, cargar_e, cargar_m, cargar_w} = 4'b1111;
          flush_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ret_drain records whether a memory wait started during a drain, so that the sequencer returns there afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      drain_cnt   <= '0;
      ret_drain   <= 1'b0;
      mem_req     <= 1'b0;
      halted      <= 1'b0;
      mem_err     <= 1'b0;
      stall_count <= '0;
    end else begin
      if (stall_inc && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state       <= S_RUN;
            stall_count <= '0;
            mem_err     <= 1'b0;
            wait_cnt    <= '0;
            halted      <= 1'b0;
          end
        end
        S_RUN: begin
          if (MemAccessM) begin
            state     <= S_MEM_WAIT;
            ret_drain <= 1'b0;
            mem_req   <= 1'b1;
            wait_cnt  <= '0;
          end else if (!PCSrcE && !load_use && HaltD) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_LAST;
          end
        end
        S_MEM_WAIT: begin
          if (mem_ack) begin
            state   <= ret_drain ? S_DRAIN : S_RUN;
            mem_req <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= S_HALTED;
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            halted  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (MemAccessM) begin
            state     <= S_MEM_WAIT;
            ret_drain <= 1'b1;
            mem_req   <= 1'b1;
            wait_cnt  <= '0;
          end else if (drain_cnt == '0) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a flag-and-counter behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int AW           = 4;
  localparam int DRAIN_CYCLES = 4;
  localparam int MEM_TIMEOUT  = 255;
  localparam int CW           = 16;
  localparam int STALL_MAX    = (1 << CW) - 1;

  logic          clk        = 1'b0;
  logic          reset      = 1'b0;
  logic          start      = 1'b0;
  logic [AW-1:0] RA1D       = '0;
  logic [AW-1:0] RA2D       = '0;
  logic [AW-1:0] WA3E       = '0;
  logic          RegWriteE  = 1'b0;
  logic          MemtoRegE  = 1'b0;
  logic          PCSrcE     = 1'b0;
  logic          MemAccessM = 1'b0;
  logic          HaltD      = 1'b0;
  logic          mem_ack    = 1'b0;
  logic          cargar_f, cargar_d, cargar_e, cargar_m, cargar_w;
  logic          flush_d, flush_e, mem_req, halted, mem_err;
  logic [CW-1:0] stall_count;
  logic [4:0]    cargarVec;
  logic [1:0]    flushVec;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign cargarVec = {cargar_f, cargar_d, cargar_e, cargar_m, cargar_w};
  assign flushVec  = {flush_d, flush_e};

  pipe_hazard_ctrl #(
    .AW(AW), .DRAIN_CYCLES(DRAIN_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .HaltD(HaltD), .mem_ack(mem_ack),
    .cargar_f(cargar_f), .cargar_d(cargar_d), .cargar_e(cargar_e),
    .cargar_m(cargar_m), .cargar_w(cargar_w),
    .flush_d(flush_d), .flush_e(flush_e),
    .mem_req(mem_req), .halted(halted), .mem_err(mem_err),
    .stall_count(stall_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic memAcc, input logic pc, input logic ld,
                               input logic rw, input logic halt, input logic ack,
                               input logic [AW-1:0] ra1, input logic [AW-1:0] ra2, input logic [AW-1:0] wa3);
    @(posedge clk);
    #1;
    start      = st;
    MemAccessM = memAcc;
    PCSrcE     = pc;
    MemtoRegE  = ld;
    RegWriteE  = rw;
    HaltD      = halt;
    mem_ack    = ack;
    RA1D       = ra1;
    RA2D       = ra2;
    WA3E       = wa3;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Behavioural model: mRunning covers both normal flow and draining, and mWaiting overlays a memory wait
  // that remembers which of those two it came from.
  bit         mRunning, mDraining, mWaiting, mHalted, mErr, mReq;
  int         mStalls, mElapsed, mDrainLeft;
  logic [4:0] expCargar;
  logic [1:0] expFlush;
  bit         hazard, stallHit;

  always @(negedge clk) begin
    if (!reset) begin
      mRunning = 0; mDraining = 0; mWaiting = 0; mHalted = 0; mErr = 0; mReq = 0;
      mStalls = 0; mElapsed = 0; mDrainLeft = 0;
    end
    hazard    = MemtoRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));
    expCargar = '0;
    expFlush  = '0;
    stallHit  = 0;
    if (reset) begin
      if (mWaiting) begin
        if (mem_ack) expCargar = 5'b11111;
        else stallHit = 1;
      end else if (mRunning && mDraining) begin
        if (MemAccessM) stallHit = 1;
        else begin expCargar = 5'b01111; expFlush = 2'b10; end
      end else if (mRunning) begin
        if (MemAccessM) stallHit = 1;
        else if (PCSrcE) begin expCargar = 5'b11111; expFlush = 2'b11; end
        else if (hazard) begin expCargar = 5'b00111; expFlush = 2'b01; stallHit = 1; end
        else if (HaltD) begin expCargar = 5'b01111; expFlush = 2'b10; end
        else expCargar = 5'b11111;
      end
    end
    checkOutput("model_cargar", 32'(cargarVec), 32'(expCargar));
    checkOutput("model_flush", 32'(flushVec), 32'(expFlush));
    checkOutput("model_mem_req", 32'(mem_req), 32'(mReq));
    checkOutput("model_halted", 32'(halted), 32'(mHalted));
    checkOutput("model_mem_err", 32'(mem_err), 32'(mErr));
    checkOutput("model_stall_count", 32'(stall_count), 32'(mStalls));
    if (reset) begin
      if (stallHit && mStalls < STALL_MAX) mStalls++;
      if (mWaiting) begin
        if (mem_ack) begin
          mWaiting = 0; mReq = 0;
        end else begin
          mElapsed++;
          if (mElapsed > MEM_TIMEOUT) begin
            mWaiting = 0; mRunning = 0; mDraining = 0; mReq = 0; mErr = 1; mHalted = 1;
          end
        end
      end else if (mRunning) begin
        if (MemAccessM) begin
          mWaiting = 1; mReq = 1; mElapsed = 0;
        end else if (mDraining) begin
          mDrainLeft--;
          if (mDrainLeft == 0) begin mRunning = 0; mDraining = 0; mHalted = 1; end
        end else if (!PCSrcE && !hazard && HaltD) begin
          mDraining = 1; mDrainLeft = DRAIN_CYCLES;
        end
      end else if (start) begin
        mRunning = 1; mHalted = 0; mErr = 0; mStalls = 0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    settle();
    checkOutput("reset_cargar", 32'(cargarVec), 32'd0);
    checkOutput("reset_stall", 32'(stall_count), 32'd0);

    // Asynchronous reset while a memory request is outstanding
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0, '0, '0);
    settle();
    checkOutput("memEntry0_cargar", 32'(cargarVec), 32'd0);
    idleCycle();
    settle();
    checkOutput("memWait0_req", 32'(mem_req), 32'd1);
    idleCycle();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("asyncReset_req", 32'(mem_req), 32'd0);
    checkOutput("asyncReset_cargar", 32'(cargarVec), 32'd0);
    checkOutput("asyncReset_stall", 32'(stall_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(0, 1, 1, 1, 1, 1, 1, 4'd3, 4'd3, 4'd3);
    settle();
    checkOutput("idleHold_cargar", 32'(cargarVec), 32'd0);
    checkOutput("idleHold_req", 32'(mem_req), 32'd0);

    // Load-use bubble, then the same hazard overridden by a taken branch
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 4'd5, 4'd3, 4'd3);
    settle();
    checkOutput("loadUse_cargar", 32'(cargarVec), 32'h07);
    checkOutput("loadUse_flush", 32'(flushVec), 32'h1);
    idleCycle();
    settle();
    checkOutput("loadUse_stall", 32'(stall_count), 32'd1);
    checkOutput("run_cargar", 32'(cargarVec), 32'h1f);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 4'd5, 4'd3, 4'd3);
    settle();
    checkOutput("branch_cargar", 32'(cargarVec), 32'h1f);
    checkOutput("branch_flush", 32'(flushVec), 32'h3);
    idleCycle();
    settle();
    checkOutput("branch_stall", 32'(stall_count), 32'd1);

    // Memory access acknowledged after five request cycles
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0, '0, '0);
    settle();
    checkOutput("memEntry_cargar", 32'(cargarVec), 32'd0);
    for (int i = 0; i < 5; i++) begin
      idleCycle();
      settle();
      checkOutput("memWait_cargar", 32'(cargarVec), 32'd0);
      checkOutput("memWait_req", 32'(mem_req), 32'd1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, '0, '0, '0);
    settle();
    checkOutput("memAck_cargar", 32'(cargarVec), 32'h1f);
    idleCycle();
    settle();
    checkOutput("memDone_stall", 32'(stall_count), 32'd7);
    checkOutput("memDone_req", 32'(mem_req), 32'd0);
    checkOutput("memDone_cargar", 32'(cargarVec), 32'h1f);

    // Halt drains the pipe, then start restarts it
    applyStimulus(0, 0, 0, 0, 0, 1, 0, '0, '0, '0);
    settle();
    checkOutput("haltD_cargar", 32'(cargarVec), 32'h0f);
    checkOutput("haltD_flush", 32'(flushVec), 32'h2);
    for (int k = 1; k <= 5; k++) begin
      idleCycle();
      settle();
      checkOutput("drain_halted", 32'(halted), (k == 5) ? 32'd1 : 32'd0);
      checkOutput("drain_cargar", 32'(cargarVec), (k == 5) ? 32'd0 : 32'h0f);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    idleCycle();
    settle();
    checkOutput("restart_halted", 32'(halted), 32'd0);
    checkOutput("restart_cargar", 32'(cargarVec), 32'h1f);

    // Memory timeout without an acknowledge
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0, '0, '0);
    for (int j = 1; j <= 257; j++) begin
      idleCycle();
      settle();
      if (j == 256) begin
        checkOutput("preTimeout_err", 32'(mem_err), 32'd0);
        checkOutput("preTimeout_req", 32'(mem_req), 32'd1);
      end
      if (j == 257) begin
        checkOutput("timeout_err", 32'(mem_err), 32'd1);
        checkOutput("timeout_halted", 32'(halted), 32'd1);
        checkOutput("timeout_stall", 32'(stall_count), 32'd257);
      end
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    idleCycle();
    settle();
    checkOutput("errClear", 32'(mem_err), 32'd0);

    // Random traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      reset      = ($urandom_range(299) != 0);
      start      = ($urandom_range(7) == 0);
      MemAccessM = ($urandom_range(9) == 0);
      PCSrcE     = ($urandom_range(7) == 0);
      MemtoRegE  = ($urandom_range(1) == 0);
      RegWriteE  = ($urandom_range(3) != 0);
      HaltD      = ($urandom_range(19) == 0);
      mem_ack    = ($urandom_range(2) == 0);
      RA1D       = ($urandom_range(3) == 0) ? AW'($urandom_range(15)) : AW'($urandom_range(3));
      RA2D       = AW'($urandom_range(3));
      WA3E       = AW'($urandom_range(3));
    end
    @(posedge clk);
    #1 reset = 1'b1;
    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
